// File: rtl/tone_analyzer_pkg.sv
// Shared types and constants for the tone analyzer: FSM states, control-register
// bit positions and the smallest legal measurement window.
package tone_analyzer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam int CTRL_START = 0;
   localparam int CTRL_CONT  = 1;
   localparam int MIN_WINDOW = 2;

endpackage

// File: rtl/tone_window_stats.sv
// Per-window running max/min and rising zero-crossing accumulator for one signed rail.
// The nxt_* outputs already include the sample presented this cycle.
module tone_window_stats #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 20
) (
   input  logic                     clk,
   input  logic                     init,
   input  logic                     accept,
   input  logic signed [DATA_W-1:0] sample,
   output logic signed [DATA_W-1:0] nxt_max,
   output logic signed [DATA_W-1:0] nxt_min,
   output logic [CNT_W-1:0]         nxt_zc
);

   logic signed [DATA_W-1:0] prev_i;
   logic signed [DATA_W-1:0] run_max;
   logic signed [DATA_W-1:0] run_min;
   logic [CNT_W-1:0]         zc_run;
   logic                     crossing;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Rising crossing: previous sample negative, current one zero or positive.
   assign crossing = prev_i[DATA_W-1] & ~sample[DATA_W-1];

   always_comb begin
      nxt_max = sample;
      nxt_min = sample;
      nxt_zc  = '0;
      if (!init) begin
         nxt_max = (sample > run_max) ? sample : run_max;
         nxt_min = (sample < run_min) ? sample : run_min;
         nxt_zc  = crossing ? sat_inc(zc_run) : zc_run;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         prev_i  <= sample;
         run_max <= nxt_max;
         run_min <= nxt_min;
         zc_run  <= nxt_zc;
      end
   end

endmodule

// File: rtl/tone_analyzer.sv
// AXI-stream sink that measures an I/Q tone over a programmable window of samples,
// reporting rising zero crossings, signed I extremes and peak amplitude per window.
module tone_analyzer
   import tone_analyzer_pkg::*;
#(
   parameter logic [7:0] SR_WINDOW      = 8'd131,
   parameter logic [7:0] SR_CTRL        = 8'd132,
   parameter int         CNT_W          = 20,
   parameter int         WINDOW_DEFAULT = 1024
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               set_stb,
   input  logic [7:0]         set_addr,
   input  logic [31:0]        set_data,
   input  logic [31:0]        i_tdata,
   input  logic               i_tlast,
   input  logic               i_tvalid,
   output logic               i_tready,
   output logic               busy,
   output logic               done_stb,
   output logic [CNT_W-1:0]   zc_count,
   output logic signed [15:0] max_i,
   output logic signed [15:0] min_i,
   output logic [15:0]        amplitude
);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] win_reg;
   logic [CNT_W-1:0] win_nxt;
   logic [CNT_W-1:0] win_latched;
   logic [CNT_W-1:0] sample_cnt;
   logic             cont_reg;
   logic             first_smp;
   logic             rdy_r;
   logic             wr_win;
   logic             wr_ctrl;
   logic             ctrl_start;
   logic             ctrl_abort;
   logic             accept;
   logic             last_smp;
   logic             win_start;

   logic signed [15:0] stat_max;
   logic signed [15:0] stat_min;
   logic [CNT_W-1:0]   stat_zc;

   logic unused_inputs;
   assign unused_inputs = ^{i_tlast, i_tdata[31:16], set_data[31:CNT_W]};

   function automatic logic [CNT_W-1:0] clamp_window(input logic [CNT_W-1:0] w);
      return (w < CNT_W'(MIN_WINDOW)) ? CNT_W'(MIN_WINDOW) : w;
   endfunction

   // Span is formed at 17 bits so full-scale extremes cannot wrap before halving.
   function automatic logic [15:0] half_span(input logic signed [15:0] hi,
                                             input logic signed [15:0] lo);
      logic signed [16:0] span;
      span = 17'(hi) - 17'(lo);
      return 16'(span >>> 1);
   endfunction

   assign wr_win     = set_stb && (set_addr == SR_WINDOW);
   assign wr_ctrl    = set_stb && (set_addr == SR_CTRL);
   assign ctrl_start = wr_ctrl &&  set_data[CTRL_START];
   assign ctrl_abort = wr_ctrl && !set_data[CTRL_START];

   // A window write landing on the same edge as a window start must still be seen.
   assign win_nxt = wr_win ? clamp_window(set_data[CNT_W-1:0]) : win_reg;

   assign i_tready  = rdy_r;
   assign accept    = i_tvalid && rdy_r && (state == MEASURE);
   assign last_smp  = accept && (sample_cnt == win_latched - CNT_W'(1));
   assign win_start = (state_nxt == MEASURE) && (state != MEASURE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (ctrl_start) state_nxt = MEASURE;
         end
         MEASURE: begin
            if (ctrl_abort)    state_nxt = IDLE;
            else if (last_smp) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = (cont_reg && !ctrl_abort) ? MEASURE : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (clear) state_nxt = IDLE;
   end

   always_comb begin
      busy     = 1'b0;
      done_stb = 1'b0;
      case (state)
         MEASURE: busy     = 1'b1;
         DONE:    done_stb = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdy_r    <= 1'b0;
         win_reg  <= CNT_W'(WINDOW_DEFAULT);
         cont_reg <= 1'b0;
      end else begin
         rdy_r <= 1'b1;
         if (clear) begin
            win_reg  <= CNT_W'(WINDOW_DEFAULT);
            cont_reg <= 1'b0;
         end else begin
            win_reg <= win_nxt;
            if (wr_ctrl) cont_reg <= set_data[CTRL_CONT];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_latched <= CNT_W'(WINDOW_DEFAULT);
         sample_cnt  <= '0;
         first_smp   <= 1'b0;
      end else if (win_start) begin
         win_latched <= win_nxt;
         sample_cnt  <= '0;
         first_smp   <= 1'b1;
      end else if (accept) begin
         sample_cnt <= sample_cnt + CNT_W'(1);
         first_smp  <= 1'b0;
      end
   end

   tone_window_stats #(
      .DATA_W (16),
      .CNT_W  (CNT_W)
   ) u_stats_i (
      .clk     (clk),
      .init    (first_smp),
      .accept  (accept),
      .sample  ($signed(i_tdata[15:0])),
      .nxt_max (stat_max),
      .nxt_min (stat_min),
      .nxt_zc  (stat_zc)
   );

   // Results land on the edge that enters DONE, so they are valid alongside done_stb.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         zc_count  <= '0;
         max_i     <= '0;
         min_i     <= '0;
         amplitude <= '0;
      end else if (clear) begin
         zc_count  <= '0;
         max_i     <= '0;
         min_i     <= '0;
         amplitude <= '0;
      end else if (state_nxt == DONE) begin
         zc_count  <= stat_zc;
         max_i     <= stat_max;
         min_i     <= stat_min;
         amplitude <= half_span(stat_max, stat_min);
      end
   end

endmodule

// File: tb/tb_tone_analyzer.sv
// Directed bench for tone_analyzer: reset, default window, square wave with and
// without valid gaps, continuous windows, aborts and clear.
module tb_tone_analyzer;

   logic               clk;
   logic               reset_n;
   logic               clear;
   logic               set_stb;
   logic [7:0]         set_addr;
   logic [31:0]        set_data;
   logic [31:0]        i_tdata;
   logic               i_tlast;
   logic               i_tvalid;
   logic               i_tready;
   logic               busy;
   logic               done_stb;
   logic [19:0]        zc_count;
   logic signed [15:0] max_i;
   logic signed [15:0] min_i;
   logic [15:0]        amplitude;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int done_prev = 0;
   int done_last = 0;
   int base;

   tone_analyzer dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .set_stb   (set_stb),
      .set_addr  (set_addr),
      .set_data  (set_data),
      .i_tdata   (i_tdata),
      .i_tlast   (i_tlast),
      .i_tvalid  (i_tvalid),
      .i_tready  (i_tready),
      .busy      (busy),
      .done_stb  (done_stb),
      .zc_count  (zc_count),
      .max_i     (max_i),
      .min_i     (min_i),
      .amplitude (amplitude)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done_stb) begin
         done_cnt  <= done_cnt + 1;
         done_prev <= done_last;
         done_last <= cyc;
      end
   end

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit vld, input logic signed [15:0] iv, input bit stb,
                        input logic [7:0] addr, input logic [31:0] data);
      i_tvalid = vld;
      i_tlast  = vld;
      i_tdata  = {16'h1234, iv};
      set_stb  = stb;
      set_addr = addr;
      set_data = data;
      @(posedge clk);
      #1;
      i_tvalid = 1'b0;
      set_stb  = 1'b0;
   endtask

   task automatic smp(input logic signed [15:0] v);
      drive(1'b1, v, 1'b0, 8'd0, 32'd0);
   endtask

   task automatic idle();
      drive(1'b0, 16'sh7FFF, 1'b0, 8'd0, 32'd0);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      drive(1'b0, 16'sh0000, 1'b1, addr, data);
   endtask

   task automatic chk_res(input string tag, input int zc, input int mx, input int mn,
                          input int amp);
      chk({tag, "_zc"}, zc_count, zc);
      chk({tag, "_max"}, max_i, mx);
      chk({tag, "_min"}, min_i, mn);
      chk({tag, "_amp"}, amplitude, amp);
   endtask

   function automatic logic signed [15:0] sq(input int k, input int amp);
      return ((k / 50) % 2 == 0) ? 16'(-amp) : 16'(amp);
   endfunction

   initial begin
      reset_n  = 1'b0;
      clear    = 1'b0;
      set_stb  = 1'b0;
      set_addr = 8'd0;
      set_data = 32'd0;
      i_tdata  = 32'd0;
      i_tlast  = 1'b0;
      i_tvalid = 1'b0;

      // Reset held while samples and a start write stream in.
      for (int k = 0; k < 3; k++) drive(1'b1, 16'sd500, 1'b1, 8'd132, 32'd1);
      chk("rst_tready", i_tready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done_stb, 0);
      chk_res("rst", 0, 0, 0, 0);
      reset_n = 1'b1;
      idle();
      chk("post_rst_tready", i_tready, 1);
      chk("post_rst_busy", busy, 0);

      // Default window of 1024, alternating -3/7 gives a crossing every odd sample.
      wr(8'd132, 32'd1);
      chk("def_busy", busy, 1);
      chk("def_nodone", done_stb, 0);
      for (int k = 0; k < 1023; k++) smp((k % 2 == 1) ? 16'sd7 : -16'sd3);
      chk("def_cnt_before", done_cnt, 0);
      smp(16'sd7);
      chk("def_done", done_stb, 1);
      chk_res("def", 512, 7, -3, 5);
      idle();
      chk("def_idle_busy", busy, 0);
      chk("def_idle_done", done_stb, 0);

      // Square wave, period 100, starting on the negative half: 10 rising edges.
      wr(8'd131, 32'd1000);
      wr(8'd132, 32'd1);
      base = done_cnt;
      for (int k = 0; k < 999; k++) smp(sq(k, 1000));
      chk("sq_cnt_before", done_cnt, base);
      smp(sq(999, 1000));
      chk("sq_done", done_stb, 1);
      chk_res("sq", 10, 1000, -1000, 1000);
      idle();
      chk("sq_busy_after", busy, 0);

      // Continuous windows of 200; the sample offered in each DONE slot is dropped.
      wr(8'd131, 32'd200);
      wr(8'd132, 32'd3);
      base = done_cnt;
      for (int k = 0; k < 199; k++) smp(16'sd100);
      chk("c1_nodone", done_stb, 0);
      smp(16'sd100);
      chk("c1_done", done_stb, 1);
      chk_res("c1", 0, 100, 100, 0);
      smp(16'sd30000);
      for (int k = 0; k < 199; k++) begin
         if (k == 100) drive(1'b1, -16'sd50, 1'b1, 8'd131, 32'd2);
         else          smp((k % 2 == 1) ? 16'sd60 : -16'sd50);
      end
      chk("c2_cnt_before", done_cnt, base + 1);
      smp(16'sd60);
      chk("c2_done", done_stb, 1);
      chk_res("c2", 100, 60, -50, 55);
      smp(-16'sd30000);
      chk("c2_interval", done_last - done_prev, 201);
      smp(16'sd10);
      chk("c3_nodone", done_stb, 0);
      drive(1'b1, -16'sd5, 1'b1, 8'd131, 32'd0);
      chk("c3_done", done_stb, 1);
      chk_res("c3", 0, 10, -5, 7);
      smp(16'sd30000);
      smp(16'sd3);
      chk("c4_nodone", done_stb, 0);
      smp(16'sd4);
      chk("c4_done", done_stb, 1);
      chk_res("c4", 0, 4, 3, 0);
      wr(8'd132, 32'd0);
      chk("c_stop_busy", busy, 0);
      chk("c_stop_done", done_stb, 0);

      // Same square wave with random valid gaps carrying junk data.
      wr(8'd131, 32'd1000);
      wr(8'd132, 32'd1);
      base = done_cnt;
      for (int k = 0; k < 1000; k++) begin
         while ($urandom_range(0, 1) == 0) idle();
         if (k == 999) begin
            chk("gap_cnt_before", done_cnt, base);
            chk("gap_nodone", done_stb, 0);
         end
         smp(sq(k, 1000));
      end
      chk("gap_done", done_stb, 1);
      chk_res("gap", 10, 1000, -1000, 1000);
      idle();

      // Abort mid-window: results held, no completion even as samples keep coming.
      wr(8'd131, 32'd1000);
      wr(8'd132, 32'd1);
      base = done_cnt;
      for (int k = 0; k < 500; k++) smp(sq(k, 2000));
      wr(8'd132, 32'd0);
      chk("abort_busy", busy, 0);
      for (int k = 0; k < 600; k++) smp(sq(k, 2000));
      chk("abort_cnt", done_cnt, base);
      chk_res("abort", 10, 1000, -1000, 1000);

      // Abort landing on the final sample of a 2-sample window wins.
      wr(8'd131, 32'd2);
      wr(8'd132, 32'd1);
      smp(-16'sd7);
      drive(1'b1, 16'sd9, 1'b1, 8'd132, 32'd0);
      chk("abort_last_done", done_stb, 0);
      chk("abort_last_busy", busy, 0);
      idle();
      chk("abort_last_cnt", done_cnt, base);
      chk_res("abort_last", 10, 1000, -1000, 1000);

      // Clear during a continuous measurement, racing a window write.
      wr(8'd131, 32'd5);
      wr(8'd132, 32'd3);
      smp(16'sd1);
      smp(16'sd2);
      clear = 1'b1;
      drive(1'b1, 16'sd100, 1'b1, 8'd131, 32'd5);
      clear = 1'b0;
      chk_res("clr", 0, 0, 0, 0);
      chk("clr_busy", busy, 0);
      chk("clr_tready", i_tready, 1);
      wr(8'd132, 32'd1);
      base = done_cnt;
      for (int k = 0; k < 1023; k++) smp(16'sd1);
      chk("clr_win_cnt_before", done_cnt, base);
      smp(16'sd1);
      chk("clr_win_done", done_stb, 1);
      chk_res("clr_win", 0, 1, 1, 0);
      idle();
      chk("clr_not_cont", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
